// File: rtl/cp0_pkg.sv
// cp0 shared definitions: register numbers, SR bit layout,
// handler vector and default processor id.
package cp0_pkg;

  localparam logic [4:0] SEL_SR    = 5'd12;
  localparam logic [4:0] SEL_CAUSE = 5'd13;
  localparam logic [4:0] SEL_EPC   = 5'd14;
  localparam logic [4:0] SEL_PRID  = 5'd15;

  localparam int IM_LO = 10;
  localparam int IM_HI = 15;
  localparam int EXL   = 1;
  localparam int IE    = 0;

  localparam logic [31:0] HANDLER_PC   = 32'h0000_3008;
  localparam logic [31:0] PRID_DEFAULT = 32'h4D49_5053;

  typedef struct packed {
    logic [5:0] im;
    logic       exl;
    logic       ie;
  } sr_t;

  function automatic logic [31:0] sr_read(sr_t s);
    logic [31:0] r;
    r = '0;
    r[IM_HI:IM_LO] = s.im;
    r[EXL] = s.exl;
    r[IE] = s.ie;
    return r;
  endfunction

endpackage

// File: rtl/cp0_sync.sv
// Two-flop synchroniser for the external interrupt lines.
// Cleared by the synchronous core reset.
module cp0_sync
  import cp0_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] d,
  output logic [5:0] q
);

  logic [5:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cp0.sv
// Coprocessor 0: SR, Cause, EPC, PRId, interrupt request
// and exception return address for the next-PC selector.
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VAL = PRID_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  hw_int,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_sel,
  input  logic [31:0] cp0_din,
  output logic [31:0] cp0_dout,
  input  logic [31:0] victim_pc,
  input  logic        stall,
  input  logic        eret,
  output logic        pcint,
  output logic [31:0] epc,
  output logic        exl
);

  sr_t         sr;
  logic [31:0] epc_q;
  logic [5:0]  ip;
  logic        wr_sr;
  logic        wr_epc;
  logic        unused_vpc;

  cp0_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (hw_int),
    .q   (ip)
  );

  assign wr_sr  = cp0_we && (cp0_sel == SEL_SR);
  assign wr_epc = cp0_we && (cp0_sel == SEL_EPC);

  assign pcint = sr.ie & ~sr.exl & (|(ip & sr.im)) & ~stall & ~eret;

  // eret targets a freshly written EPC without a bubble
  assign epc = wr_epc ? cp0_din : epc_q;
  assign exl = sr.exl;

  assign unused_vpc = ^victim_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      sr    <= '0;
      epc_q <= '0;
    end else if (eret) begin
      sr.exl <= 1'b0;
      if (wr_sr) begin
        sr.im <= cp0_din[IM_HI:IM_LO];
        sr.ie <= cp0_din[IE];
      end
      if (wr_epc) epc_q <= cp0_din;
    end else if (pcint) begin
      sr.exl <= 1'b1;
      epc_q  <= {victim_pc[31:2], 2'b00};
    end else begin
      if (wr_sr) begin
        sr.im  <= cp0_din[IM_HI:IM_LO];
        sr.exl <= cp0_din[EXL];
        sr.ie  <= cp0_din[IE];
      end
      if (wr_epc) epc_q <= cp0_din;
    end
  end

  always_comb begin
    cp0_dout = '0;
    unique case (1'b1)
      (cp0_sel == SEL_SR):    cp0_dout = sr_read(sr);
      (cp0_sel == SEL_CAUSE): cp0_dout = {16'b0, ip, 10'b0};
      (cp0_sel == SEL_EPC):   cp0_dout = epc_q;
      (cp0_sel == SEL_PRID):  cp0_dout = PRID_VAL;
      default:                cp0_dout = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0.sv
// Self-checking bench for cp0: directed scenarios plus a
// randomized run against a behavioural model.
module tb_cp0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  hw_int = '0;
  logic        cp0_we = 1'b0;
  logic [4:0]  cp0_sel = '0;
  logic [31:0] cp0_din = '0;
  logic [31:0] cp0_dout;
  logic [31:0] victim_pc = '0;
  logic        stall = 1'b0;
  logic        eret = 1'b0;
  logic        pcint;
  logic [31:0] epc;
  logic        exl;

  int checks = 0;
  int failures = 0;

  // behavioural model state
  logic [5:0]  m_im;
  logic        m_ie, m_exl;
  logic [31:0] m_epc;
  logic [5:0]  m_h0, m_h1;

  always #5 clk = ~clk;

  cp0 dut (
    .clk(clk), .rst(rst), .hw_int(hw_int),
    .cp0_we(cp0_we), .cp0_sel(cp0_sel),
    .cp0_din(cp0_din), .cp0_dout(cp0_dout),
    .victim_pc(victim_pc), .stall(stall),
    .eret(eret), .pcint(pcint), .epc(epc), .exl(exl)
  );

  function automatic logic m_pcint();
    return m_ie && !m_exl && ((m_h1 & m_im) != 0)
      && !stall && !eret;
  endfunction

  function automatic logic [31:0] m_epc_out();
    return (cp0_we && cp0_sel == 5'd14) ? cp0_din : m_epc;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] s);
    case (s)
      5'd12: return {16'h0, m_im, 8'h0, m_exl, m_ie};
      5'd13: return {16'h0, m_h1, 10'h0};
      5'd14: return m_epc;
      5'd15: return 32'h4D49_5053;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_update();
    logic p;
    p = m_pcint();
    if (rst) begin
      m_im = 0; m_ie = 0; m_exl = 0; m_epc = 0;
      m_h0 = 0; m_h1 = 0;
    end else begin
      if (eret) begin
        m_exl = 0;
        if (cp0_we && cp0_sel == 5'd12) begin
          m_im = cp0_din[15:10]; m_ie = cp0_din[0];
        end
        if (cp0_we && cp0_sel == 5'd14) m_epc = cp0_din;
      end else if (p) begin
        m_exl = 1;
        m_epc = victim_pc & 32'hFFFF_FFFC;
      end else if (cp0_we) begin
        if (cp0_sel == 5'd12) begin
          m_im = cp0_din[15:10]; m_exl = cp0_din[1];
          m_ie = cp0_din[0];
        end
        if (cp0_sel == 5'd14) m_epc = cp0_din;
      end
      m_h1 = m_h0;
      m_h0 = hw_int;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic mtc0(input logic [4:0] s, input logic [31:0] d);
    cp0_we = 1; cp0_sel = s; cp0_din = d;
    tick();
    cp0_we = 0;
  endtask

  task automatic clear_irq();
    hw_int = 0; stall = 0;
    tick(); tick();
    eret = 1; tick(); eret = 0;
  endtask

  task automatic test_reset();
    rst = 1; hw_int = 6'h3F; cp0_we = 1;
    cp0_sel = 5'd12; cp0_din = 32'hFFFF_FFFF;
    tick(); tick();
    rst = 0; cp0_we = 0; hw_int = 0; #1;
    checks++; if (pcint !== 1'b0) begin failures++; $display("FAIL reset_pcint got=%b exp=0", pcint); end
    checks++; if (exl !== 1'b0) begin failures++; $display("FAIL reset_exl got=%b exp=0", exl); end
    checks++; if (epc !== 32'h0) begin failures++; $display("FAIL reset_epc got=%h exp=0", epc); end
    checks++; if (cp0_dout !== 32'h0) begin failures++; $display("FAIL reset_sr got=%h exp=0", cp0_dout); end
    cp0_sel = 5'd15; #1;
    checks++; if (cp0_dout !== 32'h4D49_5053) begin failures++; $display("FAIL reset_prid got=%h exp=4d495053", cp0_dout); end
    cp0_sel = 5'd14; #1;
    checks++; if (cp0_dout !== 32'h0) begin failures++; $display("FAIL reset_epcreg got=%h exp=0", cp0_dout); end
  endtask

  task automatic test_latency();
    mtc0(5'd12, 32'h0000_0401);
    victim_pc = 32'h0000_1236;
    hw_int = 6'h01; #1;
    checks++; if (pcint !== 1'b0) begin failures++; $display("FAIL lat_pre got=%b exp=0", pcint); end
    tick(); #1;
    checks++; if (pcint !== 1'b0) begin failures++; $display("FAIL lat_n got=%b exp=0", pcint); end
    tick(); #1;
    checks++; if (pcint !== 1'b1) begin failures++; $display("FAIL lat_n1 got=%b exp=1", pcint); end
    tick(); cp0_sel = 5'd14; #1;
    checks++; if (cp0_dout !== 32'h0000_1234) begin failures++; $display("FAIL lat_epc got=%h exp=00001234", cp0_dout); end
    checks++; if (exl !== 1'b1) begin failures++; $display("FAIL lat_exl got=%b exp=1", exl); end
    checks++; if (pcint !== 1'b0) begin failures++; $display("FAIL lat_once got=%b exp=0", pcint); end
    clear_irq();
  endtask

  task automatic test_mask_stall();
    mtc0(5'd12, 32'h0000_0001);
    hw_int = 6'h01;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      checks++; if (pcint !== 1'b0) begin failures++; $display("FAIL mask_%0d got=%b exp=0", i, pcint); end
    end
    stall = 1;
    mtc0(5'd12, 32'h0000_0401);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (pcint !== 1'b0) begin failures++; $display("FAIL stall_%0d got=%b exp=0", i, pcint); end
      tick();
    end
    stall = 0; victim_pc = 32'h0000_4444; #1;
    checks++; if (pcint !== 1'b1) begin failures++; $display("FAIL stall_release got=%b exp=1", pcint); end
    tick(); #1;
    checks++; if (exl !== 1'b1) begin failures++; $display("FAIL stall_exl got=%b exp=1", exl); end
    clear_irq();
  endtask

  task automatic test_eret();
    mtc0(5'd12, 32'h0000_0403);
    victim_pc = 32'h0000_5550;
    hw_int = 6'h01; tick(); tick(); #1;
    checks++; if (pcint !== 1'b0) begin failures++; $display("FAIL eret_exlmask got=%b exp=0", pcint); end
    eret = 1; #1;
    checks++; if (pcint !== 1'b0) begin failures++; $display("FAIL eret_pcint got=%b exp=0", pcint); end
    checks++; if (epc !== 32'h0000_4444) begin failures++; $display("FAIL eret_epc got=%h exp=00004444", epc); end
    tick(); eret = 0; #1;
    checks++; if (exl !== 1'b0) begin failures++; $display("FAIL eret_exl got=%b exp=0", exl); end
    checks++; if (pcint !== 1'b1) begin failures++; $display("FAIL eret_reeval got=%b exp=1", pcint); end
    tick();
    clear_irq();
  endtask

  task automatic test_epc_fwd();
    cp0_we = 1; cp0_sel = 5'd14;
    cp0_din = 32'h0000_2000; eret = 1; #1;
    checks++; if (epc !== 32'h0000_2000) begin failures++; $display("FAIL fwd_comb got=%h exp=00002000", epc); end
    checks++; if (cp0_dout !== 32'h0000_5550) begin failures++; $display("FAIL fwd_nobypass got=%h exp=00005550", cp0_dout); end
    tick(); cp0_we = 0; eret = 0; #1;
    checks++; if (epc !== 32'h0000_2000) begin failures++; $display("FAIL fwd_reg got=%h exp=00002000", epc); end
    checks++; if (cp0_dout !== 32'h0000_2000) begin failures++; $display("FAIL fwd_read got=%h exp=00002000", cp0_dout); end
  endtask

  task automatic test_collision();
    mtc0(5'd12, 32'h0000_0401);
    hw_int = 6'h01; tick(); tick();
    cp0_we = 1; cp0_sel = 5'd12; cp0_din = 32'h0; #1;
    checks++; if (pcint !== 1'b1) begin failures++; $display("FAIL coll_pcint got=%b exp=1", pcint); end
    tick(); cp0_we = 0; #1;
    checks++; if (cp0_dout !== 32'h0000_0403) begin failures++; $display("FAIL coll_sr got=%h exp=00000403", cp0_dout); end
    clear_irq();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 3) == 0) hw_int = 6'($urandom);
      cp0_we = ($urandom_range(0, 3) == 0);
      cp0_sel = 5'($urandom_range(10, 17));
      cp0_din = $urandom;
      if ($urandom_range(0, 1) == 0) cp0_din[15:10] = 6'h3F;
      victim_pc = $urandom;
      stall = ($urandom_range(0, 3) == 0);
      eret = ($urandom_range(0, 7) == 0);
      #1;
      checks++; if (pcint !== m_pcint()) begin failures++; $display("FAIL rnd_pcint cyc=%0d got=%b exp=%b", i, pcint, m_pcint()); end
      checks++; if (epc !== m_epc_out()) begin failures++; $display("FAIL rnd_epc cyc=%0d got=%h exp=%h", i, epc, m_epc_out()); end
      checks++; if (exl !== m_exl) begin failures++; $display("FAIL rnd_exl cyc=%0d got=%b exp=%b", i, exl, m_exl); end
      checks++; if (cp0_dout !== m_read(cp0_sel)) begin failures++; $display("FAIL rnd_dout cyc=%0d sel=%0d got=%h exp=%h", i, cp0_sel, cp0_dout, m_read(cp0_sel)); end
      tick();
    end
    rst = 0;
  endtask

  initial begin
    m_im = 0; m_ie = 0; m_exl = 0; m_epc = 0;
    m_h0 = 0; m_h1 = 0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_mask_stall();
    test_eret();
    test_epc_fwd();
    test_collision();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
